pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/otter_pkg.sv | 22 ++
 rtl/redirect_prio.sv | 71 +++++++
 rtl/pc_redirect_ctrl.sv | 95 +++++++++
 tb/tb_pc_redirect_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types for the OTTER fetch-redirect logic: FSM state, next-PC source
// selector and the default reset PC.
package otter_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    PC4    = 3'd0,
    HOLD   = 3'd1,
    JAL    = 3'd2,
    JALR   = 3'd3,
    BRANCH = 3'd4,
    TRAP   = 3'd5,
    MRET   = 3'd6
  } pc_src_t;

endpackage

// File: rtl/redirect_prio.sv
// Combinational next-PC source selector: trap > mret > EX redirect > stall > pc+4.
// Macro OTTER_MISALIGN_TRAP_EN turns misaligned EX targets into an exception.
module redirect_prio
  import otter_pkg::*;
(
  input  state_t      state,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  input  logic        br_taken,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] branch_tgt,
  output pc_src_t     src,
  output logic        redirect,
  output logic        misalign,
  output logic [31:0] ex_tgt
);

  logic    ex_take;
  pc_src_t ex_src;

  // EX redirects are dropped in FLUSH: the instruction in EX is already dead.
  assign ex_take = ex_valid & (ex_jal | ex_jalr | (ex_branch & br_taken))
                 & (state == RUN);

  always_comb begin
    ex_tgt = branch_tgt;
    ex_src = BRANCH;
    if (ex_jal) begin
      ex_tgt = jal_tgt;
      ex_src = JAL;
    end else if (ex_jalr) begin
      ex_tgt = {jalr_tgt[31:1], 1'b0};
      ex_src = JALR;
    end
  end

  always_comb begin
    src      = PC4;
    redirect = 1'b0;
    misalign = 1'b0;
    if (trap_req) begin
      src      = TRAP;
      redirect = 1'b1;
    end else if (mret_req) begin
      src      = MRET;
      redirect = 1'b1;
    end else if (ex_take) begin
`ifdef OTTER_MISALIGN_TRAP_EN
      if (ex_tgt[1:0] != 2'b00) begin
        src      = HOLD;
        misalign = 1'b1;
      end else begin
        src      = ex_src;
        redirect = 1'b1;
      end
`else
      src      = ex_src;
      redirect = 1'b1;
`endif
    end else if (stall) begin
      src = HOLD;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register, RUN/FLUSH bubble FSM and redirect counter for the OTTER fetch stage.
// Optional macro OTTER_MISALIGN_TRAP_EN: misaligned EX targets raise misalign_exc.
module pc_redirect_ctrl
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  // Counter value loaded on reset; only nonzero to exercise the wrap path.
  parameter logic [31:0] CNT_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  input  logic        br_taken,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] branch_tgt,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        redirect,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr,
  output logic [31:0] redirect_cnt,
  output state_t      state
);

  pc_src_t     src;
  logic        misalign;
  logic [31:0] ex_tgt;
  logic [31:0] pc_next;

  redirect_prio u_prio (
    .state      (state),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_jal     (ex_jal),
    .ex_jalr    (ex_jalr),
    .ex_branch  (ex_branch),
    .br_taken   (br_taken),
    .trap_req   (trap_req),
    .mret_req   (mret_req),
    .jal_tgt    (jal_tgt),
    .jalr_tgt   (jalr_tgt),
    .branch_tgt (branch_tgt),
    .src        (src),
    .redirect   (redirect),
    .misalign   (misalign),
    .ex_tgt     (ex_tgt)
  );

  assign pc_plus4 = pc + 32'd4;

  // Second bubble cycle covers the synchronous instruction-memory read latency.
  assign flush = redirect | misalign | (state == FLUSH);

`ifdef OTTER_MISALIGN_TRAP_EN
  assign misalign_exc  = misalign;
  assign misalign_addr = misalign ? ex_tgt : 32'h0;
`else
  assign misalign_exc  = 1'b0;
  assign misalign_addr = 32'h0;
`endif

  always_comb begin
    pc_next = pc_plus4;
    case (src)
      TRAP:               pc_next = trap_vec;
      MRET:               pc_next = mepc;
      JAL, JALR, BRANCH:  pc_next = ex_tgt & ~32'h3;
      HOLD:               pc_next = pc;
      default:            pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc           <= RESET_PC;
      state        <= RUN;
      redirect_cnt <= CNT_RESET;
    end else begin
      pc           <= pc_next;
      state        <= redirect ? FLUSH : RUN;
      redirect_cnt <= redirect_cnt + {31'b0, redirect};
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed table-driven bench for pc_redirect_ctrl; expectations follow the
// OTTER_MISALIGN_TRAP_EN build setting.
module tb_pc_redirect_ctrl;
  import otter_pkg::*;

`ifdef OTTER_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam logic [7:0] C_STALL = 8'h80;
  localparam logic [7:0] C_V     = 8'h40;
  localparam logic [7:0] C_JAL   = 8'h20;
  localparam logic [7:0] C_JALR  = 8'h10;
  localparam logic [7:0] C_BR    = 8'h08;
  localparam logic [7:0] C_TK    = 8'h04;
  localparam logic [7:0] C_TRAP  = 8'h02;
  localparam logic [7:0] C_MRET  = 8'h01;

  typedef struct {
    logic        rst;
    logic [7:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] tvec;
    logic [31:0] epc;
    logic        chk_comb;
    logic        e_redir;
    logic        e_flush;
    logic        e_mis;
    logic [31:0] e_maddr;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_st;
  } vec_t;

  vec_t vecs[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ex_valid, ex_jal, ex_jalr, ex_branch, br_taken;
  logic        trap_req, mret_req;
  logic [31:0] jal_tgt, jalr_tgt, branch_tgt, trap_vec, mepc;
  logic [31:0] pc, pc_plus4, misalign_addr, redirect_cnt;
  logic        flush, redirect, misalign_exc;
  state_t      state;
  logic [31:0] pc_w, pc_plus4_w, misalign_addr_w, redirect_cnt_w;
  logic        flush_w, redirect_w, misalign_exc_w;
  state_t      state_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .CLK(clk), .RST(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_branch(ex_branch), .br_taken(br_taken),
    .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req), .mepc(mepc),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .redirect(redirect),
    .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
    .redirect_cnt(redirect_cnt), .state(state)
  );

  pc_redirect_ctrl #(.CNT_RESET(32'hFFFF_FFFF)) u_wrap (
    .CLK(clk), .RST(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_branch(ex_branch), .br_taken(br_taken),
    .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req), .mepc(mepc),
    .pc(pc_w), .pc_plus4(pc_plus4_w), .flush(flush_w), .redirect(redirect_w),
    .misalign_exc(misalign_exc_w), .misalign_addr(misalign_addr_w),
    .redirect_cnt(redirect_cnt_w), .state(state_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] t,
                       input logic [31:0] tv, input logic [31:0] me);
    {stall, ex_valid, ex_jal, ex_jalr, ex_branch, br_taken, trap_req, mret_req} = c;
    jal_tgt    = t;
    jalr_tgt   = t;
    branch_tgt = t;
    trap_vec   = tv;
    mepc       = me;
  endtask

  task automatic add(input logic r, input logic [7:0] c, input logic [31:0] t,
                     input logic [31:0] tv, input logic [31:0] me, input logic chk,
                     input logic er, input logic ef, input logic em, input logic [31:0] ema,
                     input logic [31:0] ep, input logic [31:0] ec, input logic es);
    vec_t v;
    v.rst = r; v.ctl = c; v.tgt = t; v.tvec = tv; v.epc = me; v.chk_comb = chk;
    v.e_redir = er; v.e_flush = ef; v.e_mis = em; v.e_maddr = ema;
    v.e_pc = ep; v.e_cnt = ec; v.e_st = es;
    vecs.push_back(v);
  endtask

  initial begin
    // rst ctl tgt tvec mepc chk | redir flush mis maddr pc cnt state
    add(0, C_V|C_BR|C_TK, 32'h80, 0, 0, 1,  1, 1, 0, 0, 32'h80,  1, 1);
    add(0, 8'h00,         0,      0, 0, 1,  0, 1, 0, 0, 32'h84,  1, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h88,  1, 0);
    add(0, C_STALL|C_V|C_JAL, 32'h200, 0, 0, 1, 1, 1, 0, 0, 32'h200, 2, 1);
    add(0, C_V|C_BR|C_TK, 32'h80, 0, 0, 1,  0, 1, 0, 0, 32'h204, 2, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h208, 2, 0);
    add(0, C_V|C_BR|C_TK, 32'h40, 0, 0, 1,  1, 1, 0, 0, 32'h40,  3, 1);
    add(0, C_TRAP,        0, 32'h1C0, 0, 1, 1, 1, 0, 0, 32'h1C0, 4, 1);
    add(0, 8'h00,         0,      0, 0, 1,  0, 1, 0, 0, 32'h1C4, 4, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h1C8, 4, 0);
    add(0, C_STALL,       0,      0, 0, 1,  0, 0, 0, 0, 32'h1C8, 4, 0);
    add(0, C_JAL,         32'h200, 0, 0, 1, 0, 0, 0, 0, 32'h1CC, 4, 0);
    add(0, C_V|C_BR,      32'h80, 0, 0, 1,  0, 0, 0, 0, 32'h1D0, 4, 0);
    add(0, C_MRET,        0, 0, 32'h44, 1,  1, 1, 0, 0, 32'h44,  5, 1);
    add(0, 8'h00,         0,      0, 0, 1,  0, 1, 0, 0, 32'h48,  5, 0);
    add(0, C_TRAP|C_MRET|C_V|C_JAL, 32'h300, 32'h1C0, 32'h44, 1, 1, 1, 0, 0, 32'h1C0, 6, 1);
    add(0, C_MRET|C_V|C_JAL, 32'h300, 0, 32'h50, 1, 1, 1, 0, 0, 32'h50, 7, 1);
    add(0, 8'h00,         0,      0, 0, 1,  0, 1, 0, 0, 32'h54,  7, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h58,  7, 0);
    add(0, C_V|C_JALR,    32'h302, 0, 0, 1, !MIS, 1, MIS, MIS ? 32'h302 : 32'h0,
        MIS ? 32'h58 : 32'h300, MIS ? 7 : 8, !MIS);
    add(0, 8'h00,         0,      0, 0, 1,  0, !MIS, 0, 0, MIS ? 32'h5C : 32'h304, MIS ? 7 : 8, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, MIS ? 32'h60 : 32'h308, MIS ? 7 : 8, 0);
    add(0, C_V|C_JALR,    32'h125, 0, 0, 1, 1, 1, 0, 0, 32'h124, MIS ? 8 : 9, 1);
    add(0, C_STALL,       0,      0, 0, 1,  0, 1, 0, 0, 32'h124, MIS ? 8 : 9, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h128, MIS ? 8 : 9, 0);
    add(0, C_V|C_BR|C_TK, 32'h1002, 0, 0, 1, !MIS, 1, MIS, MIS ? 32'h1002 : 32'h0,
        MIS ? 32'h128 : 32'h1000, MIS ? 8 : 10, !MIS);
    add(0, 8'h00,         0,      0, 0, 1,  0, !MIS, 0, 0, MIS ? 32'h12C : 32'h1004, MIS ? 8 : 10, 0);
    add(0, C_V|C_BR|C_TK, 32'h80, 0, 0, 1,  1, 1, 0, 0, 32'h80, MIS ? 9 : 11, 1);
    // reset wins over a trap arriving in the FLUSH cycle
    add(1, C_TRAP,        0, 32'h1C0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0);
    add(0, 8'h00,         0,      0, 0, 1,  0, 0, 0, 0, 32'h4,   0, 0);

    rst = 1'b1;
    drive(8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_cnt", redirect_cnt, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_misalign", {31'b0, misalign_exc}, 32'h0);
    check("rst_state", {31'b0, state}, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);

    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("seq_pc", pc, 32'(4 * i));
      check("seq_flush", {31'b0, flush}, 32'h0);
    end

    // free-run up to pc=0x100 before the table
    repeat (61) @(posedge clk);
    @(negedge clk);
    check("run_to_100", pc, 32'h100);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].ctl, vecs[i].tgt, vecs[i].tvec, vecs[i].epc);
      #1;
      if (vecs[i].chk_comb) begin
        check($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, vecs[i].e_redir});
        check($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].e_flush});
        check($sformatf("v%0d_misalign", i), {31'b0, misalign_exc}, {31'b0, vecs[i].e_mis});
        check($sformatf("v%0d_maddr", i), misalign_addr, vecs[i].e_maddr);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_cnt", i), redirect_cnt, vecs[i].e_cnt);
      check($sformatf("v%0d_state", i), {31'b0, state}, {31'b0, vecs[i].e_st});
      @(negedge clk);
    end
    rst = 1'b0;

    // counter wrap and pc+4 wrap
    check("wrap_cnt_pre", redirect_cnt_w, 32'hFFFF_FFFF);
    drive(C_V|C_JAL, 32'hFFFF_FFFC, 0, 0);
    @(posedge clk); #1;
    check("wrap_cnt", redirect_cnt_w, 32'h0);
    check("main_cnt", redirect_cnt, 32'h1);
    check("pc_top", pc, 32'hFFFF_FFFC);
    check("pc_plus4_wrap", pc_plus4, 32'h0);
    @(negedge clk);
    drive(8'h00, 0, 0, 0);
    @(posedge clk); #1;
    check("pc_wrapped", pc, 32'h0);
    check("pc_wrapped_w", pc_w, 32'h0);
    check("pc_plus4_after", pc_plus4, 32'h4);
    check("flush_bubble2", {31'b0, flush}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
